// File: rtl/stopwatch_mode_ctrl_pkg.sv
// Shared types and constants for the stopwatch front-panel controller.
// Holds FSM/mode encodings, keypad bit indices and default widths.
package stopwatch_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int KEY_W_DEF  = 12;
    localparam int KEY_HASH   = 11;
    localparam int KEY_STAR   = 9;

    typedef enum logic [1:0] {
        SW_IDLE = 2'd0,
        SW_RUN  = 2'd1,
        SW_STOP = 2'd2,
        SW_LAP  = 2'd3
    } sw_state_t;

    typedef enum logic {
        MODE_CLOCK     = 1'b0,
        MODE_STOPWATCH = 1'b1
    } mode_t;

    function automatic int idx_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_mode_ctrl_if.sv
// Panel-side bundle of stopwatch_mode_ctrl: raw inputs, datapath words, controls.
// Carries lap_cnt only when LAP_CNT_EN is defined.
interface stopwatch_mode_ctrl_if
    import stopwatch_pkg::*;
#(
    parameter int KEY_W  = KEY_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              switch;
    logic [KEY_W-1:0]  in_data;
    logic [DATA_W-1:0] sw_data;
    logic [DATA_W-1:0] clk_data;
    logic              sw_run;
    logic              sw_clear;
    logic              mode;
    logic [DATA_W-1:0] out_data;
`ifdef LAP_CNT_EN
    logic [3:0]        lap_cnt;

    modport master (output switch, in_data, sw_data, clk_data,
                    input  sw_run, sw_clear, mode, out_data, lap_cnt);
    modport slave  (input  switch, in_data, sw_data, clk_data,
                    output sw_run, sw_clear, mode, out_data, lap_cnt);
`else
    modport master (output switch, in_data, sw_data, clk_data,
                    input  sw_run, sw_clear, mode, out_data);
    modport slave  (input  switch, in_data, sw_data, clk_data,
                    output sw_run, sw_clear, mode, out_data);
`endif
endinterface

// File: rtl/stopwatch_mode_ctrl_key_debounce.sv
// Generic-width level debouncer: registers the raw vector, waits DEBOUNCE_CYC
// stable cycles and emits a one-cycle event plus the set bit's index.
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int W            = KEY_W_DEF,
    parameter int DEBOUNCE_CYC = 16,
    parameter bit ONEHOT_CHK   = 1'b1,
    parameter bit ARM_AT_RST   = 1'b1,
    localparam int IDX_W       = idx_w(W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     raw,
    output logic             evt,
    output logic [IDX_W-1:0] evt_idx
);
    localparam int               CNT_W   = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic [W-1:0]     in_q;
    logic [CNT_W-1:0] cnt;
    logic             armed;
    logic             raw_ok;
    logic             q_ok;
    logic             stable;

    function automatic logic [IDX_W-1:0] bit_idx(input logic [W-1:0] v);
        bit_idx = '0;
        for (int i = 0; i < W; i++)
            if (v[i]) bit_idx = IDX_W'(i);
    endfunction

    always_comb begin
        raw_ok = ONEHOT_CHK ? ($countones(raw) <= 1) : 1'b1;
        q_ok   = ONEHOT_CHK ? $onehot(in_q) : (in_q != '0);
        stable = (cnt == CNT_MAX);
    end

    // A keypad held through reset has to be seen released before it is armed.
    // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q    <= '0;
            cnt     <= '0;
            armed   <= ARM_AT_RST;
            evt     <= 1'b0;
            evt_idx <= '0;
        end else begin
            in_q <= raw;
            if (raw != in_q || !raw_ok)
                cnt <= '0;
            else if (!stable)
                cnt <= cnt + 1'b1;

            evt <= 1'b0;
            if (stable && in_q == '0) begin
                armed <= 1'b1;
            end else if (stable && q_ok && armed) begin
                evt     <= 1'b1;
                evt_idx <= bit_idx(in_q);
                armed   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/stopwatch_mode_ctrl.sv
// Stopwatch front-panel controller: debounced keypad/switch, run/stop/lap FSM
// and display source selection. Optional lap counter behind LAP_CNT_EN.
module stopwatch_mode_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 16,
    parameter int KEY_W        = KEY_W_DEF,
    parameter int DATA_W       = DATA_W_DEF
) (
    input logic                  clk,
    input logic                  rst_n,
    stopwatch_mode_ctrl_if.slave bus
);
    localparam int KIDX_W = idx_w(KEY_W);

    logic              key_evt;
    logic [KIDX_W-1:0] key_idx;
    logic              sw_evt;
    logic              sw_idx_unused;

    sw_state_t         state, state_nxt;
    mode_t             mode_q;
    logic              sw_run_q, run_nxt;
    logic              sw_clear_q, clear_nxt;
    logic              lap_load;
    logic              key_ok, is_hash, is_star;
    logic [DATA_W-1:0] lap_reg, lap_disp;
    logic [DATA_W-1:0] out_q, disp_nxt;

    key_debounce #(
        .W(KEY_W), .DEBOUNCE_CYC(DEBOUNCE_CYC), .ONEHOT_CHK(1'b1), .ARM_AT_RST(1'b0)
    ) u_key_db (
        .clk(clk), .rst_n(rst_n), .raw(bus.in_data), .evt(key_evt), .evt_idx(key_idx)
    );

    key_debounce #(
        .W(1), .DEBOUNCE_CYC(DEBOUNCE_CYC), .ONEHOT_CHK(1'b0), .ARM_AT_RST(1'b1)
    ) u_switch_db (
        .clk(clk), .rst_n(rst_n), .raw(bus.switch), .evt(sw_evt), .evt_idx(sw_idx_unused)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        clear_nxt = 1'b0;
        lap_load  = 1'b0;
        key_ok    = key_evt && !sw_evt && (mode_q == MODE_STOPWATCH);
        is_hash   = key_ok && (key_idx == KIDX_W'(KEY_HASH));
        is_star   = key_ok && (key_idx == KIDX_W'(KEY_STAR));

        case (state)
            SW_IDLE: if (is_hash) state_nxt = SW_RUN;
                     else if (is_star) clear_nxt = 1'b1;
            SW_RUN:  if (is_hash) state_nxt = SW_STOP;
                     else if (is_star) begin
                         state_nxt = SW_LAP;
                         lap_load  = 1'b1;
                     end
            SW_STOP: if (is_hash) state_nxt = SW_RUN;
                     else if (is_star) begin
                         state_nxt = SW_IDLE;
                         clear_nxt = 1'b1;
                     end
            SW_LAP:  if (is_hash) state_nxt = SW_STOP;
                     else if (is_star) state_nxt = SW_RUN;
            default: state_nxt = SW_IDLE;
        endcase

        run_nxt  = (state_nxt == SW_RUN) || (state_nxt == SW_LAP);
        disp_nxt = bus.sw_data;
        if (mode_q == MODE_CLOCK)
            disp_nxt = bus.clk_data;
        else if (state == SW_LAP)
            disp_nxt = lap_disp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SW_IDLE;
            mode_q     <= MODE_CLOCK;
            sw_run_q   <= 1'b0;
            sw_clear_q <= 1'b0;
            lap_reg    <= '0;
            out_q      <= '0;
        end else begin
            state      <= state_nxt;
            sw_run_q   <= run_nxt;
            sw_clear_q <= clear_nxt;
            out_q      <= disp_nxt;
            if (sw_evt)
                mode_q <= (mode_q == MODE_CLOCK) ? MODE_STOPWATCH : MODE_CLOCK;
            if (lap_load)
                lap_reg <= bus.sw_data;
        end
    end

`ifdef LAP_CNT_EN
    logic [3:0] lap_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lap_cnt_q <= '0;
        else if (clear_nxt)
            lap_cnt_q <= '0;
        else if (lap_load && lap_cnt_q != 4'd9)
            lap_cnt_q <= lap_cnt_q + 4'd1;
    end

    assign bus.lap_cnt = lap_cnt_q;
    assign lap_disp    = {lap_cnt_q, lap_reg[DATA_W-5:0]};
`else
    assign lap_disp    = lap_reg;
`endif

    assign bus.sw_run   = sw_run_q;
    assign bus.sw_clear = sw_clear_q;
    assign bus.mode     = mode_q;
    assign bus.out_data = out_q;

endmodule

// File: tb/tb_stopwatch_mode_ctrl.sv
// Self-checking bench for stopwatch_mode_ctrl: directed scenarios plus random
// stimulus against a behavioural model of the panel rules.
`timescale 1ns/1ps
module tb_stopwatch_mode_ctrl;

    localparam int DEB    = 16;
    localparam int KEY_W  = 12;
    localparam int DATA_W = 24;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stopwatch_mode_ctrl_if #(.KEY_W(KEY_W), .DATA_W(DATA_W)) bus ();

    stopwatch_mode_ctrl #(.DEBOUNCE_CYC(DEB), .KEY_W(KEY_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: histories of registered samples decide acceptance.
    typedef enum {M_IDLE, M_RUN, M_STOP, M_LAP} m_state_t;
    logic [KEY_W-1:0] key_hist[$];
    logic             sw_hist[$];
    bit               key_armed, sw_armed, key_pend, sw_pend;
    logic [KEY_W-1:0] key_pend_val;
    m_state_t         m_state;
    bit               m_mode, m_run, m_clear;
    logic [23:0]      m_lap, m_out;
    int               m_lapcnt;

    function automatic bit key_stable();
        if (key_hist.size() != DEB) return 1'b0;
        foreach (key_hist[i]) if (key_hist[i] !== key_hist[0]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit sw_stable();
        if (sw_hist.size() != DEB) return 1'b0;
        foreach (sw_hist[i]) if (sw_hist[i] !== sw_hist[0]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [23:0] lap_view();
`ifdef LAP_CNT_EN
        logic [3:0] c = m_lapcnt[3:0];
        return {c, m_lap[19:0]};
`else
        return m_lap;
`endif
    endfunction

    task automatic model_reset();
        key_hist = {};
        key_hist.push_back('0);
        sw_hist = {};
        sw_hist.push_back(1'b0);
        key_armed = 1'b0;
        sw_armed  = 1'b1;
        key_pend  = 1'b0;
        sw_pend   = 1'b0;
        key_pend_val = '0;
        m_state = M_IDLE;
        m_mode = 0; m_run = 0; m_clear = 0;
        m_lap = '0; m_out = '0; m_lapcnt = 0;
    endtask

    task automatic model_step();
        bit take, hash, star, kst, sst;
        m_state_t nxt;
        take = key_pend && !sw_pend && m_mode;
        hash = take && key_pend_val == 12'h800;
        star = take && key_pend_val == 12'h200;
        m_out = !m_mode ? bus.clk_data : (m_state == M_LAP ? lap_view() : bus.sw_data);
        nxt = m_state;
        m_clear = 0;
        if (hash)
            nxt = (m_state == M_RUN || m_state == M_LAP) ? M_STOP : M_RUN;
        if (star) begin
            case (m_state)
                M_IDLE: m_clear = 1;
                M_RUN:  begin nxt = M_LAP; m_lap = bus.sw_data;
                              if (m_lapcnt < 9) m_lapcnt++; end
                M_STOP: begin nxt = M_IDLE; m_clear = 1; end
                M_LAP:  nxt = M_RUN;
            endcase
        end
        if (m_clear) m_lapcnt = 0;
        m_state = nxt;
        m_run = (nxt == M_RUN || nxt == M_LAP);
        if (sw_pend) m_mode = !m_mode;

        kst = key_stable();
        key_pend = kst && ($countones(key_hist[0]) == 1) && key_armed;
        key_pend_val = key_hist[0];
        if (kst && key_hist[0] == '0) key_armed = 1;
        if (key_pend) key_armed = 0;
        sst = sw_stable();
        sw_pend = sst && sw_hist[0] && sw_armed;
        if (sst && !sw_hist[0]) sw_armed = 1;
        if (sw_pend) sw_armed = 0;

        key_hist.push_back(bus.in_data);
        if (key_hist.size() > DEB) void'(key_hist.pop_front());
        sw_hist.push_back(bus.switch);
        if (sw_hist.size() > DEB) void'(sw_hist.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic drive(input logic [KEY_W-1:0] k, input logic s, input int n);
        bus.in_data = k;
        bus.switch  = s;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        bus.in_data = '0; bus.switch = 1'b0;
        bus.sw_data = '0; bus.clk_data = 24'h654321;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (bus.sw_run !== 1'b0 || bus.sw_clear !== 1'b0 || bus.mode !== 1'b0 || bus.out_data !== 24'h0) begin
            n_fail++;
            $display("FAIL reset: run=%b clr=%b mode=%b out=%h want 0 0 0 000000",
                     bus.sw_run, bus.sw_clear, bus.mode, bus.out_data);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_mode_switch();
        bus.sw_data = 24'h000000; bus.clk_data = 24'h123456;
        drive('0, 1'b1, DEB + 1);
        n_tests++;
        if (bus.mode !== 1'b0) begin n_fail++; $display("FAIL mode_early: mode=%b want 0", bus.mode); end
        tick();
        n_tests++;
        if (bus.mode !== 1'b1) begin n_fail++; $display("FAIL mode_on: mode=%b want 1", bus.mode); end
        n_tests++;
        if (bus.out_data !== 24'h123456) begin n_fail++; $display("FAIL mode_out_clk: out=%h want 123456", bus.out_data); end
        tick();
        n_tests++;
        if (bus.out_data !== 24'h000000) begin n_fail++; $display("FAIL mode_out_sw: out=%h want 000000", bus.out_data); end
        drive('0, 1'b0, DEB + 2);
        n_tests++;
        if (bus.mode !== 1'b1) begin n_fail++; $display("FAIL mode_release: mode=%b want 1", bus.mode); end
    endtask

    task automatic test_start();
        logic exp;
        bus.in_data = 12'h800;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 17 || c == 18 || c == 20) begin
                exp = (c >= 18);
                n_tests++;
                if (bus.sw_run !== exp) begin
                    n_fail++;
                    $display("FAIL start_c%0d: sw_run=%b want %b", c, bus.sw_run, exp);
                end
            end
        end
        drive('0, 1'b0, DEB + 2);
    endtask

    task automatic test_lap();
        logic [23:0] want;
`ifdef LAP_CNT_EN
        want = 24'h112345;
`else
        want = 24'h012345;
`endif
        bus.sw_data = 24'h012345;
        drive(12'h200, 1'b0, 20);
        bus.sw_data = 24'h012399;
        drive('0, 1'b0, DEB + 2);
        n_tests++;
        if (bus.out_data !== want) begin n_fail++; $display("FAIL lap_hold: out=%h want %h", bus.out_data, want); end
        n_tests++;
        if (bus.sw_run !== 1'b1) begin n_fail++; $display("FAIL lap_run: sw_run=%b want 1", bus.sw_run); end
        drive(12'h200, 1'b0, 20);
        n_tests++;
        if (bus.out_data !== 24'h012399) begin n_fail++; $display("FAIL lap_exit: out=%h want 012399", bus.out_data); end
        drive('0, 1'b0, DEB + 2);
    endtask

    task automatic test_clear();
        int pulses;
        drive(12'h800, 1'b0, 20);
        n_tests++;
        if (bus.sw_run !== 1'b0) begin n_fail++; $display("FAIL stop: sw_run=%b want 0", bus.sw_run); end
        drive('0, 1'b0, DEB + 2);
        for (int rep = 0; rep < 2; rep++) begin
            pulses = 0;
            bus.in_data = 12'h200;
            for (int c = 0; c < 20; c++) begin
                tick();
                if (bus.sw_clear === 1'b1) pulses++;
            end
            n_tests++;
            if (pulses !== 1) begin n_fail++; $display("FAIL clear_pulse%0d: pulses=%0d want 1", rep, pulses); end
            n_tests++;
            if (bus.sw_run !== 1'b0) begin n_fail++; $display("FAIL clear_run%0d: sw_run=%b want 0", rep, bus.sw_run); end
            drive('0, 1'b0, DEB + 2);
        end
    endtask

    task automatic test_bounce();
        int changes = 0;
        for (int c = 0; c < 80; c++) begin
            bus.in_data = ((c / 5) % 2 == 0) ? 12'h800 : 12'h000;
            tick();
            if (bus.sw_run !== 1'b0 || bus.sw_clear !== 1'b0) changes++;
        end
        bus.in_data = 12'hA00;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.sw_run !== 1'b0 || bus.sw_clear !== 1'b0) changes++;
        end
        n_tests++;
        if (changes !== 0) begin n_fail++; $display("FAIL bounce: active cycles=%0d want 0", changes); end
        drive('0, 1'b0, DEB + 2);
    endtask

    task automatic test_clock_mode();
        drive(12'h800, 1'b0, 20);
        drive('0, 1'b0, DEB + 2);
        drive('0, 1'b1, DEB + 2);
        n_tests++;
        if (bus.mode !== 1'b0) begin n_fail++; $display("FAIL clk_mode: mode=%b want 0", bus.mode); end
        bus.clk_data = 24'h235959;
        drive(12'h800, 1'b1, 20);
        n_tests++;
        if (bus.sw_run !== 1'b1) begin n_fail++; $display("FAIL clk_ignore: sw_run=%b want 1", bus.sw_run); end
        n_tests++;
        if (bus.out_data !== 24'h235959) begin n_fail++; $display("FAIL clk_out: out=%h want 235959", bus.out_data); end
        drive('0, 1'b0, DEB + 2);
    endtask

    task automatic test_back_to_back();
        drive('0, 1'b1, DEB + 2);
        drive('0, 1'b0, DEB + 2);
        drive(12'h800, 1'b1, 20);
        n_tests++;
        if (bus.mode !== 1'b0 || bus.sw_run !== 1'b1) begin
            n_fail++;
            $display("FAIL simul: mode=%b sw_run=%b want 0 1", bus.mode, bus.sw_run);
        end
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.sw_run !== 1'b0 || bus.sw_clear !== 1'b0 || bus.mode !== 1'b0 || bus.out_data !== 24'h0) begin
            n_fail++;
            $display("FAIL async_reset: run=%b clr=%b mode=%b out=%h want 0 0 0 000000",
                     bus.sw_run, bus.sw_clear, bus.mode, bus.out_data);
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        drive(12'h800, 1'b1, 60);
        n_tests++;
        if (bus.mode !== 1'b1 || bus.sw_run !== 1'b0) begin
            n_fail++;
            $display("FAIL held_thru_reset: mode=%b sw_run=%b want 1 0", bus.mode, bus.sw_run);
        end
        drive('0, 1'b0, DEB + 2);
        drive(12'h800, 1'b0, 20);
        n_tests++;
        if (bus.sw_run !== 1'b1) begin n_fail++; $display("FAIL rearm: sw_run=%b want 1", bus.sw_run); end
        drive('0, 1'b0, DEB + 2);
    endtask

    task automatic test_random();
        logic [KEY_W-1:0] k;
        logic s = 1'b0;
        int cyc = 0;
        for (int seg = 0; seg < 150; seg++) begin
            int len = $urandom_range(1, 40);
            case ($urandom_range(0, 5))
                0, 1:    k = 12'h000;
                2:       k = 12'h800;
                3:       k = 12'h200;
                4:       k = 12'h001 << $urandom_range(0, 8);
                default: k = 12'hA00;
            endcase
            if ($urandom_range(0, 3) == 0) s = ~s;
            for (int c = 0; c < len; c++) begin
                bus.in_data  = k;
                bus.switch   = s;
                bus.sw_data  = 24'($urandom);
                bus.clk_data = 24'($urandom);
                tick();
                cyc++;
                n_tests++;
                if (bus.sw_run !== m_run || bus.sw_clear !== m_clear ||
                    bus.mode !== m_mode || bus.out_data !== m_out) begin
                    n_fail++;
                    $display("FAIL random cyc %0d: got run=%b clr=%b mode=%b out=%h want run=%b clr=%b mode=%b out=%h",
                             cyc, bus.sw_run, bus.sw_clear, bus.mode, bus.out_data,
                             m_run, m_clear, m_mode, m_out);
                end
`ifdef LAP_CNT_EN
                n_tests++;
                if (bus.lap_cnt !== 4'(m_lapcnt)) begin
                    n_fail++;
                    $display("FAIL random_lapcnt cyc %0d: got %0d want %0d", cyc, bus.lap_cnt, m_lapcnt);
                end
`endif
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mode_switch();
        test_start();
        test_lap();
        test_clear();
        test_bounce();
        test_clock_mode();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
